// File: rtl/btn_led_pkg.sv
// Shared types and helpers for the button/LED arbiter: group sizing, FSM states,
// per-group masks and the round-robin pick.
package btn_led_pkg;

    localparam int unsigned N_GROUPS = 4;
    localparam int unsigned GROUP_W  = 4;
    localparam int unsigned LED_W    = N_GROUPS * GROUP_W;
    localparam int unsigned IDX_W    = $clog2(N_GROUPS);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} arb_state_t;
    typedef logic [N_GROUPS-1:0] grp_mask_t;
    typedef logic [IDX_W-1:0]    grp_idx_t;

    function automatic grp_mask_t onehot(input grp_idx_t idx);
        onehot = grp_mask_t'(1) << idx;
    endfunction

    // Nearest set bit at or after ptr, circularly; relies on N_GROUPS being a power of two for the wrap.
    function automatic grp_idx_t rr_pick(input grp_mask_t req, input grp_idx_t ptr);
        grp_idx_t idx;
        rr_pick = ptr;
        for (int k = N_GROUPS - 1; k >= 0; k--) begin
            idx = ptr + grp_idx_t'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter, debounced level and a
// single-cycle pulse on each debounced press (0->1).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             meta;
    logic             synced;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            meta   <= raw;
            synced <= meta;
            press  <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Input has disagreed for the full window: accept it.
                level <= synced;
                cnt   <= '0;
                press <= synced;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_led_arbiter.sv
// Board button/LED controller: debounced presses become sticky requests that a
// round-robin arbiter services one at a time, loading switch nibbles into LED groups.
module btn_led_arbiter
    import btn_led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned HOLD_CYCLES     = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_GROUPS-1:0] btn,
    input  logic [LED_W-1:0]    sw,
    output logic [LED_W-1:0]    led,
    output grp_mask_t           grant,
    output logic                busy,
    output grp_mask_t           pending
);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    grp_mask_t         press;
    grp_mask_t         clr_mask;
    logic [LED_W-1:0]  sw_meta;
    logic [LED_W-1:0]  sw_sync;
    arb_state_t        state;
    grp_idx_t          sel;
    grp_idx_t          rr_ptr;
    grp_idx_t          winner;
    logic [HOLD_W-1:0] hold_cnt;

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn[g]),
            .press(press[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign clr_mask = (state == LOAD) ? onehot(sel) : '0;
    assign winner   = rr_pick(pending, rr_ptr);

    // Set is applied after clear so a press landing on the servicing cycle is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | press;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            led      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        sel   <= winner;
                        grant <= onehot(winner);
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int g = 0; g < N_GROUPS; g++) begin
                        if (sel == grp_idx_t'(g)) begin
                            led[g*GROUP_W +: GROUP_W] <= sw_sync[g*GROUP_W +: GROUP_W];
                        end
                    end
                    rr_ptr   <= sel + grp_idx_t'(1);
                    grant    <= '0;
                    hold_cnt <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_led_arbiter.sv
// Self-checking bench for btn_led_arbiter: directed scenarios plus random button
// activity, compared cycle by cycle against a behavioural model.
module tb_btn_led_arbiter;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = '0;
    logic [15:0] sw  = '0;
    logic [15:0] led;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  pending;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [3:0]  s1, s2, deb, last, press_q;
    int          run [4];
    logic [15:0] sw1, sw2, m_led;
    logic [3:0]  m_grant, m_pending;
    logic        m_busy;
    int          left, m_sel, m_ptr;

    btn_led_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .sw     (sw),
        .led    (led),
        .grant  (grant),
        .busy   (busy),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // One clock edge of the model: a button is accepted once its synchronized value
    // has held for DEB sampled edges; each grant owns the arbiter for HOLD+1 cycles.
    task automatic model_step();
        logic [3:0] np;
        logic [3:0] newpress;
        int w;
        if (rst) begin
            s1 = '0; s2 = '0; deb = '0; last = '0; press_q = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
            sw1 = '0; sw2 = '0; m_led = '0; m_grant = '0; m_pending = '0;
            m_busy = 1'b0; left = 0; m_sel = 0; m_ptr = 0;
        end else begin
            np = m_pending;
            if (left == HOLD + 1) begin
                m_led[m_sel*4 +: 4] = sw2[m_sel*4 +: 4];
                np[m_sel] = 1'b0;
                m_ptr = (m_sel + 1) % 4;
            end
            m_grant = '0;
            if (left > 0) begin
                left--;
            end else if (m_pending != 0) begin
                w = 0;
                for (int k = 0; k < 4; k++) begin
                    if (m_pending[(m_ptr + k) % 4]) begin
                        w = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_sel = w;
                m_grant[w] = 1'b1;
                left = HOLD + 1;
            end
            newpress = '0;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == last[i]) begin
                    if (run[i] < 1000) run[i]++;
                end else begin
                    run[i] = 1;
                end
                last[i] = s2[i];
                if (s2[i] != deb[i] && run[i] >= DEB) begin
                    deb[i] = s2[i];
                    newpress[i] = s2[i];
                end
            end
            np = np | press_q;
            press_q = newpress;
            s2 = s1; s1 = btn;
            sw2 = sw1; sw1 = sw;
            m_pending = np;
            m_busy = (left > 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int grant_idx(input logic [3:0] g);
        grant_idx = -1;
        for (int i = 0; i < 4; i++) if (g[i]) grant_idx = i;
    endfunction

    task automatic test_reset();
        sw = 16'h5555;
        btn = '0;
        apply_reset();
        for (int c = 0; c < 50; c++) begin
            checks++;
            if ({led, grant, busy, pending} !== 25'h0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got led=%h grant=%b busy=%b pending=%b expected all zero",
                         c, led, grant, busy, pending);
            end
            checks++;
            if ({led, grant, busy, pending} !== {m_led, m_grant, m_busy, m_pending}) begin
                errors++;
                $display("FAIL model_reset cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                         c, led, grant, busy, pending, m_led, m_grant, m_busy, m_pending);
            end
            tick();
        end
    endtask

    task automatic test_single_press();
        int gcnt = 0, bcnt = 0, p_rise = -1, l_rise = -1;
        logic [3:0] gval = '0;
        sw = 16'h0005;
        for (int c = 0; c < 50; c++) begin
            checks++;
            if ({led, grant, busy, pending} !== {m_led, m_grant, m_busy, m_pending}) begin
                errors++;
                $display("FAIL model_single cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                         c, led, grant, busy, pending, m_led, m_grant, m_busy, m_pending);
            end
            if (grant != 0) begin gcnt++; gval = grant; end
            if (busy) bcnt++;
            if (pending[0] && p_rise < 0) p_rise = c;
            if (led == 16'h0005 && l_rise < 0) l_rise = c;
            btn = (c < 20) ? 4'b0001 : 4'b0000;
            tick();
        end
        checks++;
        if (gcnt != 1 || gval !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant got count=%0d value=%b expected count=1 value=0001", gcnt, gval);
        end
        checks++;
        if (bcnt != HOLD + 1) begin
            errors++;
            $display("FAIL single_busy got %0d cycles expected %0d", bcnt, HOLD + 1);
        end
        checks++;
        if (p_rise < 0 || l_rise - p_rise != 2) begin
            errors++;
            $display("FAIL single_latency got pending_at=%0d led_at=%0d expected led 2 cycles after pending",
                     p_rise, l_rise);
        end
        checks++;
        if (led !== 16'h0005) begin
            errors++;
            $display("FAIL single_led got %h expected 0005", led);
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        for (int c = 0; c < 30; c++) begin
            checks++;
            if ({led, grant, busy, pending} !== {m_led, m_grant, m_busy, m_pending}) begin
                errors++;
                $display("FAIL model_glitch cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                         c, led, grant, busy, pending, m_led, m_grant, m_busy, m_pending);
            end
            if (pending != 0 || grant != 0) bad++;
            btn = (c < 3) ? 4'b0100 : 4'b0000;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_reject got %0d cycles with pending/grant set expected 0", bad);
        end
        checks++;
        if (led !== 16'h0005) begin
            errors++;
            $display("FAIL glitch_led_persist got %h expected 0005", led);
        end
    endtask

    task automatic test_simultaneous();
        int order[$];
        int when[$];
        sw = 16'h5555;
        apply_reset();
        for (int c = 0; c < 60; c++) begin
            checks++;
            if ({led, grant, busy, pending} !== {m_led, m_grant, m_busy, m_pending}) begin
                errors++;
                $display("FAIL model_simul cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                         c, led, grant, busy, pending, m_led, m_grant, m_busy, m_pending);
            end
            if (grant != 0) begin order.push_back(grant_idx(grant)); when.push_back(c); end
            btn = (c < 20) ? 4'b1111 : 4'b0000;
            tick();
        end
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("FAIL simul_count got %0d grants expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != i) begin
                    errors++;
                    $display("FAIL simul_order slot=%0d got group %0d expected %0d", i, order[i], i);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (when[i] - when[i-1] != HOLD + 2) begin
                    errors++;
                    $display("FAIL simul_spacing slot=%0d got %0d cycles expected %0d",
                             i, when[i] - when[i-1], HOLD + 2);
                end
            end
        end
        checks++;
        if (led !== 16'h5555) begin
            errors++;
            $display("FAIL simul_led got %h expected 5555", led);
        end
    endtask

    task automatic test_rr_fairness();
        int order[$];
        sw = 16'hABCD;
        apply_reset();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if ({led, grant, busy, pending} !== {m_led, m_grant, m_busy, m_pending}) begin
                errors++;
                $display("FAIL model_rr cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                         c, led, grant, busy, pending, m_led, m_grant, m_busy, m_pending);
            end
            if (grant != 0) order.push_back(grant_idx(grant));
            if (c < 10)                btn = 4'b0010;
            else if (c >= 25 && c < 35) btn = 4'b1001;
            else                       btn = 4'b0000;
            tick();
        end
        checks++;
        if (order.size() != 3 || order[0] != 1 || order[1] != 3 || order[2] != 0) begin
            errors++;
            $display("FAIL rr_order got %p expected '{1, 3, 0}", order);
        end
        checks++;
        if (led !== 16'hA0CD) begin
            errors++;
            $display("FAIL rr_led got %h expected a0cd", led);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        bit found;
        int late = 0;
        sw = 16'h1234;
        apply_reset();
        btn = 4'b0101;
        n = 0;
        while (pending == 0 && n < 20) begin tick(); n++; end
        btn = 4'b0000;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (busy && grant == 0 && pending[2]) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midhold_reach got busy=%b pending=%b expected HOLD with pending[2]", busy, pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({led, busy, pending, grant} !== 25'h0) begin
            errors++;
            $display("FAIL midhold_reset got led=%h busy=%b pending=%b grant=%b expected all zero",
                     led, busy, pending, grant);
        end
        for (int c = 0; c < 40; c++) begin
            checks++;
            if ({led, grant, busy, pending} !== {m_led, m_grant, m_busy, m_pending}) begin
                errors++;
                $display("FAIL model_midhold cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                         c, led, grant, busy, pending, m_led, m_grant, m_busy, m_pending);
            end
            if (grant != 0) late++;
            tick();
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL midhold_no_grant got %0d grant cycles expected 0", late);
        end
    endtask

    task automatic test_random();
        int seg = 0;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            checks++;
            if ({led, grant, busy, pending} !== {m_led, m_grant, m_busy, m_pending}) begin
                errors++;
                $display("FAIL model_random cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                         c, led, grant, busy, pending, m_led, m_grant, m_busy, m_pending);
            end
            rst = ($urandom_range(0, 199) == 0);
            if (seg == 0) begin
                btn = 4'($urandom_range(0, 15));
                seg = $urandom_range(1, 14);
                if ($urandom_range(0, 2) == 0) sw = 16'($urandom);
            end else begin
                seg--;
            end
            tick();
        end
        rst = 1'b0;
        btn = '0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_rr_fairness();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_led_arbiter.md
Name: btn_led_arbiter

Overview:
- Controller for the 4-button / 16-switch / 16-LED board resource. Each button i owns LED group i (led[4i+3:4i]), which is loaded from switch group i (sw[4i+3:4i]).
- Raw buttons are synchronized and debounced, then press edges are converted to sticky requests.
- A round-robin arbiter services one request at a time: it copies the switch nibble into that group's LED register, then holds off further service for a programmable period.
- Sits between the board pins and the LED drivers, replacing direct combinational button/switch gating.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive stable synchronized cycles required before a button's debounced state changes (>=2)
- HOLD_CYCLES, 50000000, cycles spent in HOLD after each grant (>=1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn  input  4  raw push buttons, bit i = button i, asynchronous to clk
- sw  input  16  raw switches, asynchronous to clk
- led  output  16  registered LED outputs
- grant  output  4  one-hot, high for the single LOAD cycle of the serviced group
- busy  output  1  high in LOAD and HOLD
- pending  output  4  sticky request bits, one per button

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, rst.
- Reset values: led=0, grant=0, busy=0, pending=0, state=IDLE, rr_ptr=0, all debounce counters=0, debounced states=0, sync flops=0, hold counter=0.
- Synchronization: btn and sw each pass through 2-flop synchronizers. sw is used only as its synchronized value.
- Debounce, per button:
  - The counter increments while the synced value differs from the debounced state, and clears to 0 whenever they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced state takes the synced value on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never toggles the debounced state.
- Press detect: a 1-cycle press pulse is generated on a debounced 0->1 transition only. Releases generate no pulse.
- Pending:
  - A press pulse sets pending[i] on the next edge.
  - pending[i] clears on the LOAD cycle that services i.
  - If set and clear coincide for the same bit, set wins.
  - Pressing an already pending button has no further effect; there is no queue depth beyond 1 per button.
- State machine, states IDLE, LOAD, HOLD:
  - IDLE: if pending != 0, pick the winner (see round-robin) into sel and go to LOAD. Otherwise stay.
  - LOAD, exactly 1 cycle:
    - grant = onehot(sel), busy=1.
    - led[4*sel+3:4*sel] <= synced sw[4*sel+3:4*sel], visible the following cycle.
    - Other LED groups are unchanged.
    - pending[sel] cleared; rr_ptr <= (sel+1) mod 4.
    - Hold counter cleared; next state HOLD.
  - HOLD:
    - busy=1, grant=0.
    - The counter increments each cycle. When it equals HOLD_CYCLES-1, go to IDLE.
    - Presses during HOLD set pending but are not serviced until IDLE.
- Round-robin: search pending starting at index rr_ptr, ascending with wrap 3->0. The first set bit wins.
- Latency: pending bit set in cycle N with the FSM in IDLE gives LOAD in N+1 and the LED update visible in N+2.
- LED persistence: LEDs retain their last loaded value indefinitely. Only reset clears them.
- Reset mid-operation: rst in any state returns everything to its reset values on that edge. Pending requests are discarded.

Decomposition:
- Package btn_led_pkg:
  - N_GROUPS=4, GROUP_W=4.
  - typedef enum logic [1:0] {IDLE, LOAD, HOLD} arb_state_t.
  - typedef logic [N_GROUPS-1:0] grp_mask_t.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES):
  - Contents: 2-flop synchronizer, counter, debounced state and rising-edge pulse.
  - Instantiated 4x via generate.
- Top contains: sw synchronizer, pending register, round-robin pick, FSM, hold counter, LED registers.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
- Reset then idle, with sw=16'h5555 and btn=0 for 50 cycles -> led=0, pending=0, busy=0, grant=0 throughout.
- Single press: btn[0] high for 20 cycles, sw=16'h0005 -> exactly one grant=4'b0001 pulse, led=16'h0005 2 cycles after pending[0] rises, busy high for exactly 9 cycles, other groups stay 0.
- Glitch rejection: btn[2] high for 3 cycles then low -> pending stays 0 and no grant.
- Simultaneous presses: btn=4'b1111 held together, sw=16'h5555, rr_ptr=0 -> grants in order 0,1,2,3, each separated by 10 cycles. Final led=16'h5555.
- Round-robin fairness: after group 1 is serviced, press btn[0] and btn[3] together -> group 3 is granted before group 0.
- Reset mid-HOLD: assert rst for 1 cycle during HOLD with pending[2]=1 -> the next cycle shows led=0, pending=0, busy=0, and no later grant occurs.
